// File: rtl/light_pkg.sv
// Shared types and constants for the lamp-sequence monitor.
// Also carries the transmitter state typedef used elsewhere in the slice.
package light_pkg;

    typedef enum logic [2:0] {
        IDLE,
        L1,
        L2,
        L3,
        R1,
        R2,
        R3,
        RESYNC
    } state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_SHIFT,
        TX_STOP
    } tx_state_t;

    localparam logic [5:0] P_IDLE = 6'b000000;
    localparam logic [5:0] P_L1   = 6'b100000;
    localparam logic [5:0] P_L2   = 6'b110000;
    localparam logic [5:0] P_L3   = 6'b111000;
    localparam logic [5:0] P_R1   = 6'b000100;
    localparam logic [5:0] P_R2   = 6'b000110;
    localparam logic [5:0] P_R3   = 6'b000111;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_START = 2'd1;
    localparam logic [1:0] ERR_ORDER = 2'd2;
    localparam logic [1:0] ERR_BOTH  = 2'd3;

    // Both-sides-lit outranks whatever the FSM position implies.
    function automatic logic [1:0] err_cause(
        input logic [5:0] p,
        input logic       in_idle
    );
        if ((|p[5:3]) && (|p[2:0]))
            return ERR_BOTH;
        else if (in_idle)
            return ERR_START;
        else
            return ERR_ORDER;
    endfunction

endpackage

// File: rtl/light_monitor_sat_cnt8.sv
// 8-bit event counter that sticks at 8'hFF.
// Clear wins over a simultaneous increment.
module sat_cnt8
    import light_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       inc,
    output logic [7:0] q
);

    always_ff @(posedge clk) begin
        if (!reset_n)
            q <= 8'h00;
        else if (clear)
            q <= 8'h00;
        else if (inc && (q != 8'hFF))
            q <= q + 8'd1;
    end

endmodule

// File: rtl/light_monitor.sv
// Watches left/right lamp lines for legal three-step sequences.
// Flags out-of-order patterns and counts completions and errors.
module light_monitor
    import light_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       la,
    input  logic       lb,
    input  logic       lc,
    input  logic       ra,
    input  logic       rb,
    input  logic       rc,
    input  logic       clear,
    output logic       left_active,
    output logic       right_active,
    output logic       done_l,
    output logic       done_r,
    output logic       err,
    output logic [1:0] err_code,
    output logic [7:0] left_count,
    output logic [7:0] right_count,
    output logic [7:0] err_count
);

    logic [5:0] p;
    state_t     state;
    state_t     state_n;
    logic       done_l_n;
    logic       done_r_n;
    logic       err_n;
    logic [1:0] cause;

    assign p     = {la, lb, lc, ra, rb, rc};
    assign cause = err_cause(p, state == IDLE);

    always_comb begin
        state_n  = state;
        done_l_n = 1'b0;
        done_r_n = 1'b0;
        err_n    = 1'b0;
        case (state)
            IDLE: begin
                if (p == P_IDLE) begin
                    state_n = IDLE;
                end else if (p == P_L1) begin
                    state_n = L1;
                end else if (p == P_R1) begin
                    state_n = R1;
                end else begin
                    state_n = RESYNC;
                    err_n   = 1'b1;
                end
            end
            L1: begin
                if (p == P_L2) begin
                    state_n = L2;
                end else begin
                    state_n = RESYNC;
                    err_n   = 1'b1;
                end
            end
            L2: begin
                if (p == P_L3) begin
                    state_n = L3;
                end else begin
                    state_n = RESYNC;
                    err_n   = 1'b1;
                end
            end
            L3: begin
                if (p == P_IDLE) begin
                    state_n  = IDLE;
                    done_l_n = 1'b1;
                end else begin
                    state_n = RESYNC;
                    err_n   = 1'b1;
                end
            end
            R1: begin
                if (p == P_R2) begin
                    state_n = R2;
                end else begin
                    state_n = RESYNC;
                    err_n   = 1'b1;
                end
            end
            R2: begin
                if (p == P_R3) begin
                    state_n = R3;
                end else begin
                    state_n = RESYNC;
                    err_n   = 1'b1;
                end
            end
            R3: begin
                if (p == P_IDLE) begin
                    state_n  = IDLE;
                    done_r_n = 1'b1;
                end else begin
                    state_n = RESYNC;
                    err_n   = 1'b1;
                end
            end
            RESYNC: begin
                if (p == P_IDLE)
                    state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Flags are decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            left_active  <= 1'b0;
            right_active <= 1'b0;
            done_l       <= 1'b0;
            done_r       <= 1'b0;
            err          <= 1'b0;
            err_code     <= ERR_NONE;
        end else begin
            state        <= state_n;
            left_active  <= (state_n == L1) || (state_n == L2) ||
                            (state_n == L3);
            right_active <= (state_n == R1) || (state_n == R2) ||
                            (state_n == R3);
            done_l       <= done_l_n;
            done_r       <= done_r_n;
            err          <= err_n;
            if (err_n)
                err_code <= cause;
        end
    end

    sat_cnt8 u_left_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .inc     (done_l_n),
        .q       (left_count)
    );

    sat_cnt8 u_right_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .inc     (done_r_n),
        .q       (right_count)
    );

    sat_cnt8 u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .inc     (err_n),
        .q       (err_count)
    );

endmodule

// File: tb/tb_light_monitor.sv
// Self-checking bench for light_monitor: reference model plus directed
// scenarios and randomized lamp traffic.
module tb_light_monitor;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       la, lb, lc, ra, rb, rc;
    logic       clear;
    logic       left_active, right_active;
    logic       done_l, done_r, err;
    logic [1:0] err_code;
    logic [7:0] left_count, right_count, err_count;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    light_monitor dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .la           (la),
        .lb           (lb),
        .lc           (lc),
        .ra           (ra),
        .rb           (rb),
        .rc           (rc),
        .clear        (clear),
        .left_active  (left_active),
        .right_active (right_active),
        .done_l       (done_l),
        .done_r       (done_r),
        .err          (err),
        .err_code     (err_code),
        .left_count   (left_count),
        .right_count  (right_count),
        .err_count    (err_count)
    );

    logic [5:0] lseq [3];
    logic [5:0] rseq [3];
    initial begin
        lseq[0] = 6'b100000; lseq[1] = 6'b110000; lseq[2] = 6'b111000;
        rseq[0] = 6'b000100; rseq[1] = 6'b000110; rseq[2] = 6'b000111;
    end

    // Model: mode 0 idle, 1 left, 2 right, 3 lost; idx = steps seen.
    int         m_mode = 0;
    int         m_idx = 0;
    bit         m_done_l, m_done_r, m_err;
    logic [1:0] m_code;
    int         m_lc, m_rc, m_ec;

    always @(posedge clk) begin
        logic [5:0] pp;
        bit         both;
        bit         dl, dr, e;
        logic [1:0] c;
        pp   = {la, lb, lc, ra, rb, rc};
        both = (|pp[5:3]) && (|pp[2:0]);
        dl = 0; dr = 0; e = 0;
        c  = both ? 2'd3 : (m_mode == 0 ? 2'd1 : 2'd2);
        if (!reset_n) begin
            m_mode = 0; m_idx = 0;
            m_done_l = 0; m_done_r = 0; m_err = 0;
            m_code = 0; m_lc = 0; m_rc = 0; m_ec = 0;
        end else begin
            if (m_mode == 0) begin
                if (pp == 6'd0) ;
                else if (pp == lseq[0]) begin m_mode = 1; m_idx = 1; end
                else if (pp == rseq[0]) begin m_mode = 2; m_idx = 1; end
                else begin m_mode = 3; e = 1; end
            end else if (m_mode == 3) begin
                if (pp == 6'd0) m_mode = 0;
            end else if (m_idx == 3) begin
                if (pp == 6'd0) begin
                    if (m_mode == 1) dl = 1; else dr = 1;
                    m_mode = 0;
                end else begin
                    m_mode = 3; e = 1;
                end
            end else begin
                if (pp == (m_mode == 1 ? lseq[m_idx] : rseq[m_idx]))
                    m_idx++;
                else begin
                    m_mode = 3; e = 1;
                end
            end
            m_done_l = dl; m_done_r = dr; m_err = e;
            if (e) m_code = c;
            if (clear) begin
                m_lc = 0; m_rc = 0; m_ec = 0;
            end else begin
                if (dl && m_lc < 255) m_lc++;
                if (dr && m_rc < 255) m_rc++;
                if (e && m_ec < 255) m_ec++;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("left_active", int'(left_active), int'(m_mode == 1));
            chk("right_active", int'(right_active), int'(m_mode == 2));
            chk("done_l", int'(done_l), int'(m_done_l));
            chk("done_r", int'(done_r), int'(m_done_r));
            chk("err", int'(err), int'(m_err));
            chk("err_code", int'(err_code), int'(m_code));
            chk("left_count", int'(left_count), m_lc);
            chk("right_count", int'(right_count), m_rc);
            chk("err_count", int'(err_count), m_ec);
        end
    end

    task automatic step(input logic [5:0] p, input logic clr = 1'b0,
                        input logic rst = 1'b1);
        {la, lb, lc, ra, rb, rc} = p;
        clear   = clr;
        reset_n = rst;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic left_seq();
        step(6'b100000); step(6'b110000); step(6'b111000); step(6'b000000);
    endtask

    initial begin
        int act_cycles;
        reset_n = 1'b0; clear = 1'b0;
        {la, lb, lc, ra, rb, rc} = 6'd0;
        step(6'd0, 1'b0, 1'b0);
        started = 1'b1;
        step(6'd0, 1'b0, 1'b0);
        chk("rst_err_code", int'(err_code), 0);
        chk("rst_left_count", int'(left_count), 0);
        chk("rst_active", int'(left_active | right_active), 0);

        // V1
        step(6'd0);
        act_cycles = 0;
        step(6'b100000); act_cycles += int'(left_active);
        step(6'b110000); act_cycles += int'(left_active);
        step(6'b111000); act_cycles += int'(left_active);
        step(6'b000000);
        chk("v1_done_l", int'(done_l), 1);
        chk("v1_active_cycles", act_cycles, 3);
        chk("v1_left_count", int'(left_count), 1);
        chk("v1_err_count", int'(err_count), 0);

        // V2
        step(6'd0, 1'b0, 1'b0);
        step(6'b000100); step(6'b000110); step(6'b000111); step(6'b000000);
        chk("v2_done_r", int'(done_r), 1);
        left_seq();
        chk("v2_done_l", int'(done_l), 1);
        chk("v2_right_count", int'(right_count), 1);
        chk("v2_left_count", int'(left_count), 1);

        // V3
        step(6'd0, 1'b0, 1'b0);
        step(6'b100000);
        step(6'b111000);
        chk("v3_err", int'(err), 1);
        chk("v3_err_code", int'(err_code), 2);
        for (int i = 0; i < 3; i++) begin
            step(6'b111000);
            chk("v3_no_err", int'(err), 0);
        end
        step(6'b000000);
        chk("v3_err_count", int'(err_count), 1);

        // V4
        step(6'b100100);
        chk("v4_err", int'(err), 1);
        chk("v4_err_code", int'(err_code), 3);
        step(6'd0);

        // V5
        step(6'd0, 1'b0, 1'b0);
        for (int i = 0; i < 260; i++) left_seq();
        chk("v5_sat", int'(left_count), 255);
        step(6'b100000); step(6'b110000); step(6'b111000);
        step(6'b000000, 1'b1);
        chk("v5_done_with_clear", int'(done_l), 1);
        chk("v5_cleared", int'(left_count), 0);

        // V6
        step(6'b000100); step(6'b000110);
        chk("v6_in_r2", int'(right_active), 1);
        step(6'b000111, 1'b0, 1'b0);
        chk("v6_rst_done_r", int'(done_r), 0);
        chk("v6_rst_active", int'(right_active), 0);
        step(6'b000100);
        chk("v6_r1", int'(right_active), 1);

        // Random traffic
        step(6'd0);
        for (int n = 0; n < 600; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind < 4) begin
                for (int k = 0; k < 3; k++)
                    step(kind[0] ? rseq[k] : lseq[k],
                         ($urandom_range(0, 19) == 0));
                step(6'd0, ($urandom_range(0, 19) == 0));
            end else if (kind < 6) begin
                step(6'd0);
            end else begin
                step(6'($urandom()), ($urandom_range(0, 19) == 0),
                     ($urandom_range(0, 49) != 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
